pawn_move_validator: RTL and testbench

Parametrised, handshaked pawn-move validator for the game-play board validator. It accepts one candidate pawn move per `start` pulse and reads only the squares it needs through a one-cycle-latency board read port. It checks single push, double push with path check, and diagonal capture, including an opponent-colour check, en passant and promotion detection. It reports the result with a one-cycle `done` pulse.

---
 rtl/pawn_move_validator_if.sv | 46 ++++
 rtl/pawn_move_validator.sv | 243 ++++++++++++++++++++++++
 tb/tb_pawn_move_validator.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pawn_move_validator_if.sv
// Request/result and board-read bundle of the pawn move validator.
// slave is the validator side, master is the requester/board side.
interface pawn_move_validator_if #(
   parameter int BOARD_DIM = 8,
   parameter int PW        = 4
) ();
   localparam int CW = $clog2(BOARD_DIM);

   logic          start;
   logic [CW-1:0] old_x;
   logic [CW-1:0] old_y;
   logic [CW-1:0] new_x;
   logic [CW-1:0] new_y;
   logic [PW-1:0] piece_type;
   logic          ep_valid;
   logic [CW-1:0] ep_x;
   logic [CW-1:0] ep_y;
   logic          rd_en;
   logic [CW-1:0] rd_x;
   logic [CW-1:0] rd_y;
   logic [PW-1:0] rd_data;
   logic          busy;
   logic          done;
   logic          valid_move;
   logic          promote;
   logic          ep_capture;
   logic          double_step;

   modport slave (
      input  start, old_x, old_y, new_x, new_y,
      input  piece_type, ep_valid, ep_x, ep_y,
      input  rd_data,
      output rd_en, rd_x, rd_y,
      output busy, done, valid_move, promote,
      output ep_capture, double_step
   );

   modport master (
      output start, old_x, old_y, new_x, new_y,
      output piece_type, ep_valid, ep_x, ep_y,
      output rd_data,
      input  rd_en, rd_x, rd_y,
      input  busy, done, valid_move, promote,
      input  ep_capture, double_step
   );
endinterface

// File: rtl/pawn_move_validator.sv
// Pawn move validator: classifies one pawn move, reads at most two
// board squares through a 1-cycle read port, reports a done pulse.
module pawn_move_validator #(
   parameter int BOARD_DIM  = 8,
   parameter int PW         = 4,
   parameter int WHITE_PAWN = 5,
   parameter int BLACK_PAWN = 11,
   parameter int BLACK_BASE = 6,
   parameter int EMPTY_CODE = 15
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pawn_move_validator_if.slave bus
);
   localparam int CW = $clog2(BOARD_DIM);

   localparam logic [CW:0]   DIM_W  = (CW+1)'(BOARD_DIM);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] ROW_0  = '0;
   localparam logic [CW-1:0] ROW_L  = CW'(BOARD_DIM - 1);
   localparam logic [CW-1:0] ROW_WS = CW'(BOARD_DIM - 2);
   localparam logic [CW-1:0] ROW_BS = CW'(1);
   localparam logic [CW-1:0] ROW_WE = CW'(2);
   localparam logic [CW-1:0] ROW_BE = CW'(BOARD_DIM - 3);

   localparam logic [PW-1:0] C_WP = PW'(WHITE_PAWN);
   localparam logic [PW-1:0] C_BP = PW'(BLACK_PAWN);
   localparam logic [PW-1:0] C_BB = PW'(BLACK_BASE);
   localparam logic [PW-1:0] C_EM = PW'(EMPTY_CODE);

   localparam logic signed [CW:0] D_P1 = (CW+1)'(1);
   localparam logic signed [CW:0] D_M1 = (CW+1)'(-1);
   localparam logic signed [CW:0] D_P2 = (CW+1)'(2);
   localparam logic signed [CW:0] D_M2 = (CW+1)'(-2);

   typedef enum logic [2:0] {
      IDLE, CLASSIFY, RD_MID, CHK_MID,
      RD_DST, CHK_DST, DONE
   } state_t;

   typedef enum logic [1:0] {
      K_ILLEGAL, K_PUSH1, K_PUSH2, K_DIAG
   } kind_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_old_x;
   logic [CW-1:0] r_old_y;
   logic [CW-1:0] r_new_x;
   logic [CW-1:0] r_new_y;
   logic [CW-1:0] r_ep_x;
   logic [CW-1:0] r_ep_y;
   logic [CW-1:0] r_rd_x;
   logic [CW-1:0] r_rd_y;
   logic [PW-1:0] r_piece;
   logic          r_ep_valid;
   logic          r_done;
   logic          r_valid;
   logic          r_promote;
   logic          r_ep_cap;
   logic          r_dbl;

   logic               w_accept;
   logic               w_white;
   logic               w_pawn;
   logic               w_in_range;
   logic               w_ok;
   logic signed [CW:0] w_dx;
   logic signed [CW:0] w_dy;
   logic signed [CW:0] w_dir;
   logic signed [CW:0] w_dir2;
   logic [CW-1:0]      w_mid_y;
   logic [CW-1:0]      w_start_row;
   kind_t              w_kind;
   logic               w_empty;
   logic               w_opp;
   logic               w_ep;
   logic               w_last;
   logic               w_legal;

   // While the done pulse is out the FSM already sits in IDLE;
   // a start seen in that cycle still belongs to the finished request.
   assign w_accept = (r_state == IDLE) && bus.start && !r_done;

   assign w_white = (r_piece == C_WP);
   assign w_pawn  = w_white || (r_piece == C_BP);

   generate
      if (BOARD_DIM == (1 << CW)) begin : g_pow2
         assign w_in_range = 1'b1;
      end else begin : g_npow2
         assign w_in_range =
            ({1'b0, r_old_x} < DIM_W) &&
            ({1'b0, r_old_y} < DIM_W) &&
            ({1'b0, r_new_x} < DIM_W) &&
            ({1'b0, r_new_y} < DIM_W);
      end
   endgenerate

   assign w_ok   = w_pawn && w_in_range;
   assign w_dx   = $signed({1'b0, r_new_x}) -
                   $signed({1'b0, r_old_x});
   assign w_dy   = $signed({1'b0, r_new_y}) -
                   $signed({1'b0, r_old_y});
   assign w_dir  = w_white ? D_M1 : D_P1;
   assign w_dir2 = w_white ? D_M2 : D_P2;

   assign w_start_row = w_white ? ROW_WS : ROW_BS;
   assign w_mid_y     = w_white ? (r_old_y - ONE)
                                : (r_old_y + ONE);

   // Move kind from the latched request; illegal unless a rule matches.
   always_comb begin
      w_kind = K_ILLEGAL;
      if (w_ok && w_dx == '0 && w_dy == w_dir)
         w_kind = K_PUSH1;
      else if (w_ok && w_dx == '0 && w_dy == w_dir2 &&
               r_old_y == w_start_row)
         w_kind = K_PUSH2;
      else if (w_ok && (w_dx == D_P1 || w_dx == D_M1) &&
               w_dy == w_dir)
         w_kind = K_DIAG;
   end

   assign w_empty = (bus.rd_data == C_EM);
   assign w_opp   = w_white ?
                    (bus.rd_data >= C_BB && bus.rd_data < C_EM) :
                    (bus.rd_data < C_BB);
   assign w_ep    = w_empty && r_ep_valid &&
                    r_new_x == r_ep_x && r_new_y == r_ep_y &&
                    r_ep_y == (w_white ? ROW_WE : ROW_BE);
   assign w_last  = r_new_y == (w_white ? ROW_0 : ROW_L);

   // Destination rule for the square just read.
   always_comb begin
      w_legal = 1'b0;
      unique case (w_kind)
         K_PUSH1, K_PUSH2: w_legal = w_empty;
         K_DIAG:           w_legal = w_opp || w_ep;
         default:          w_legal = 1'b0;
      endcase
   end

   // Next-state selection.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:     if (w_accept) w_next = CLASSIFY;
         CLASSIFY: begin
            unique case (w_kind)
               K_PUSH2:         w_next = RD_MID;
               K_PUSH1, K_DIAG: w_next = RD_DST;
               default:         w_next = DONE;
            endcase
         end
         RD_MID:   w_next = CHK_MID;
         CHK_MID:  w_next = w_empty ? RD_DST : DONE;
         RD_DST:   w_next = CHK_DST;
         CHK_DST:  w_next = DONE;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // State register and the done pulse that trails DONE by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == DONE);
      end
   end

   // Capture the request on the accepting edge only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_old_x    <= '0;
         r_old_y    <= '0;
         r_new_x    <= '0;
         r_new_y    <= '0;
         r_piece    <= '0;
         r_ep_valid <= 1'b0;
         r_ep_x     <= '0;
         r_ep_y     <= '0;
      end else if (w_accept) begin
         r_old_x    <= bus.old_x;
         r_old_y    <= bus.old_y;
         r_new_x    <= bus.new_x;
         r_new_y    <= bus.new_y;
         r_piece    <= bus.piece_type;
         r_ep_valid <= bus.ep_valid;
         r_ep_x     <= bus.ep_x;
         r_ep_y     <= bus.ep_y;
      end
   end

   // Read address loads on entry to a read state and holds otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_x <= '0;
         r_rd_y <= '0;
      end else if (w_next == RD_MID) begin
         r_rd_x <= r_old_x;
         r_rd_y <= w_mid_y;
      end else if (w_next == RD_DST) begin
         r_rd_x <= r_new_x;
         r_rd_y <= r_new_y;
      end
   end

   // Results clear on accept, load from the destination check.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid   <= 1'b0;
         r_promote <= 1'b0;
         r_ep_cap  <= 1'b0;
         r_dbl     <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b0;
         r_promote <= 1'b0;
         r_ep_cap  <= 1'b0;
         r_dbl     <= 1'b0;
      end else if (r_state == CHK_DST) begin
         r_valid   <= w_legal;
         r_promote <= w_legal && w_last;
         r_ep_cap  <= w_legal && (w_kind == K_DIAG) && w_ep;
         r_dbl     <= w_legal && (w_kind == K_PUSH2);
      end
   end

   assign bus.busy        = (r_state != IDLE);
   assign bus.done        = r_done;
   assign bus.rd_en       = (r_state == RD_MID) ||
                            (r_state == RD_DST);
   assign bus.rd_x        = r_rd_x;
   assign bus.rd_y        = r_rd_y;
   assign bus.valid_move  = r_valid;
   assign bus.promote     = r_promote;
   assign bus.ep_capture  = r_ep_cap;
   assign bus.double_step = r_dbl;
endmodule

// File: tb/tb_pawn_move_validator.sv
// Bench for pawn_move_validator: directed table, random moves against
// a rule-level model, busy/start and mid-operation reset sequences.
module tb_pawn_move_validator;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pawn_move_validator_if #(.BOARD_DIM(8),  .PW(4)) b8 ();
   pawn_move_validator_if #(.BOARD_DIM(10), .PW(4)) b10 ();

   pawn_move_validator #(.BOARD_DIM(8)) u8 (
      .clk(clk), .reset_n(reset_n), .bus(b8.slave));
   pawn_move_validator #(.BOARD_DIM(10)) u10 (
      .clk(clk), .reset_n(reset_n), .bus(b10.slave));

   typedef struct {
      int ox, oy, nx, ny, pc, epv, epx, epy;
   } req_t;
   typedef struct {
      int valid, prom, epc, dbl, lat, nrd;
      int rx0, ry0, rx1, ry1;
   } exp_t;
   typedef struct {
      int dim; req_t q; int mid, dst;
      int valid, prom, epc, dbl, lat, nrd;
   } vec_t;
   typedef struct {
      int done, valid, prom, epc, dbl, busy, rd_en, rx, ry;
   } obs_t;

   int bd [10][10];
   int rq_x[$];
   int rq_y[$];
   int checks = 0;
   int errors = 0;

   // Board memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (b8.rd_en) begin
         b8.rd_data <= 4'(bd[int'(b8.rd_x)][int'(b8.rd_y)]);
         rq_x.push_back(int'(b8.rd_x));
         rq_y.push_back(int'(b8.rd_y));
      end
      if (b10.rd_en) begin
         b10.rd_data <= 4'(bd[int'(b10.rd_x)][int'(b10.rd_y)]);
         rq_x.push_back(int'(b10.rd_x));
         rq_y.push_back(int'(b10.rd_y));
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input int dim, input req_t q, input bit st);
      if (dim == 8) begin
         b8.start = st;
         b8.old_x = 3'(q.ox); b8.old_y = 3'(q.oy);
         b8.new_x = 3'(q.nx); b8.new_y = 3'(q.ny);
         b8.piece_type = 4'(q.pc);
         b8.ep_valid = (q.epv != 0);
         b8.ep_x = 3'(q.epx); b8.ep_y = 3'(q.epy);
      end else begin
         b10.start = st;
         b10.old_x = 4'(q.ox); b10.old_y = 4'(q.oy);
         b10.new_x = 4'(q.nx); b10.new_y = 4'(q.ny);
         b10.piece_type = 4'(q.pc);
         b10.ep_valid = (q.epv != 0);
         b10.ep_x = 4'(q.epx); b10.ep_y = 4'(q.epy);
      end
   endtask

   function automatic obs_t sample(input int dim);
      obs_t o;
      if (dim == 8) begin
         o.done = int'(b8.done); o.valid = int'(b8.valid_move);
         o.prom = int'(b8.promote); o.epc = int'(b8.ep_capture);
         o.dbl = int'(b8.double_step); o.busy = int'(b8.busy);
         o.rd_en = int'(b8.rd_en);
         o.rx = int'(b8.rd_x); o.ry = int'(b8.rd_y);
      end else begin
         o.done = int'(b10.done); o.valid = int'(b10.valid_move);
         o.prom = int'(b10.promote); o.epc = int'(b10.ep_capture);
         o.dbl = int'(b10.double_step); o.busy = int'(b10.busy);
         o.rd_en = int'(b10.rd_en);
         o.rx = int'(b10.rd_x); o.ry = int'(b10.rd_y);
      end
      return o;
   endfunction

   task automatic chk_zero(input string nm, input int dim);
      obs_t o = sample(dim);
      chk({nm, " busy"}, o.busy, 0);
      chk({nm, " done"}, o.done, 0);
      chk({nm, " rd_en"}, o.rd_en, 0);
      chk({nm, " valid"}, o.valid, 0);
      chk({nm, " promote"}, o.prom, 0);
      chk({nm, " ep_capture"}, o.epc, 0);
      chk({nm, " double_step"}, o.dbl, 0);
      chk({nm, " rd_x"}, o.rx, 0);
      chk({nm, " rd_y"}, o.ry, 0);
   endtask

   // Rule-level reference: which squares get read, latency, result.
   function automatic exp_t model(input int dim, input req_t q);
      exp_t e;
      int w, dir, dx, dy, d, ok, opp, ep;
      e = '{default: 0};
      e.lat = 2;
      w = (q.pc == 5) ? 1 : 0;
      dir = w ? -1 : 1;
      if (!(q.pc == 5 || q.pc == 11)) return e;
      if (q.ox >= dim || q.oy >= dim) return e;
      if (q.nx >= dim || q.ny >= dim) return e;
      dx = q.nx - q.ox;
      dy = q.ny - q.oy;
      ok = 0;
      if (dx == 0 && dy == 2 * dir &&
          q.oy == (w ? dim - 2 : 1)) begin
         e.nrd = 1; e.rx0 = q.ox; e.ry0 = q.oy + dir; e.lat = 4;
         if (bd[q.ox][q.oy + dir] != 15) return e;
         e.nrd = 2; e.rx1 = q.nx; e.ry1 = q.ny; e.lat = 6;
         ok = (bd[q.nx][q.ny] == 15);
         e.dbl = ok;
      end else if (dy == dir && dx >= -1 && dx <= 1) begin
         e.nrd = 1; e.rx0 = q.nx; e.ry0 = q.ny; e.lat = 4;
         d = bd[q.nx][q.ny];
         if (dx == 0) ok = (d == 15);
         else begin
            opp = w ? (d >= 6 && d < 15) : (d < 6);
            ep = (d == 15) && q.epv != 0 && q.nx == q.epx &&
                 q.ny == q.epy && q.epy == (w ? 2 : dim - 3);
            ok = opp || ep;
            e.epc = ok && ep;
         end
      end else return e;
      e.valid = ok;
      e.prom = ok && (q.ny == (w ? 0 : dim - 1));
      return e;
   endfunction

   task automatic run(input int dim, input req_t q,
                      input exp_t e, input string nm);
      req_t q2;
      obs_t o;
      int n0, lat;
      lat = 0;
      @(negedge clk);
      drive(dim, q, 1'b1);
      n0 = rq_x.size();
      @(posedge clk);
      @(negedge clk);
      q2.ox = $urandom_range(0, 7); q2.oy = $urandom_range(0, 7);
      q2.nx = $urandom_range(0, 7); q2.ny = $urandom_range(0, 7);
      q2.pc = $urandom_range(0, 15); q2.epv = $urandom_range(0, 1);
      q2.epx = $urandom_range(0, 7); q2.epy = $urandom_range(0, 7);
      drive(dim, q2, 1'b0);
      for (int k = 1; k <= 12 && lat == 0; k++) begin
         @(posedge clk); #1;
         o = sample(dim);
         if (o.done != 0) lat = k;
      end
      chk({nm, " latency"}, lat, e.lat);
      chk({nm, " valid"}, o.valid, e.valid);
      chk({nm, " promote"}, o.prom, e.prom);
      chk({nm, " ep_capture"}, o.epc, e.epc);
      chk({nm, " double_step"}, o.dbl, e.dbl);
      chk({nm, " reads"}, rq_x.size() - n0, e.nrd);
      if (e.nrd >= 1 && rq_x.size() > n0) begin
         chk({nm, " rd0 x"}, rq_x[n0], e.rx0);
         chk({nm, " rd0 y"}, rq_y[n0], e.ry0);
      end
      if (e.nrd == 2 && rq_x.size() > n0 + 1) begin
         chk({nm, " rd1 x"}, rq_x[n0 + 1], e.rx1);
         chk({nm, " rd1 y"}, rq_y[n0 + 1], e.ry1);
      end
      @(posedge clk); #1;
      o = sample(dim);
      chk({nm, " done width"}, o.done, 0);
      chk({nm, " held valid"}, o.valid, e.valid);
   endtask

   task automatic fill(input int v);
      for (int x = 0; x < 10; x++)
         for (int y = 0; y < 10; y++)
            bd[x][y] = v;
   endtask

   function automatic vec_t mkv(
      input int dim, ox, oy, nx, ny, pc, epv, epx, epy,
      input int mid, dst, v, p, ec, ds, lat, nrd);
      vec_t t;
      t.dim = dim; t.mid = mid; t.dst = dst;
      t.q.ox = ox; t.q.oy = oy; t.q.nx = nx; t.q.ny = ny;
      t.q.pc = pc; t.q.epv = epv; t.q.epx = epx; t.q.epy = epy;
      t.valid = v; t.prom = p; t.epc = ec; t.dbl = ds;
      t.lat = lat; t.nrd = nrd;
      return t;
   endfunction

   vec_t tv[$];

   initial begin
      req_t q, q2;
      exp_t e;
      obs_t o;
      int my, ndone, flat, m, dim;

      tv.push_back(mkv(8, 4,6,4,5, 5, 0,0,0, 15,15, 1,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,6,4,4, 5, 0,0,0,  2,15, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,6,4,4, 5, 0,0,0, 15,15, 1,0,0,1, 6,2));
      tv.push_back(mkv(8, 4,6,4,4, 5, 0,0,0, 15, 3, 0,0,0,0, 6,2));
      tv.push_back(mkv(8, 3,1,4,2,11, 0,0,0, 15, 2, 1,0,0,0, 4,1));
      tv.push_back(mkv(8, 3,1,4,2,11, 0,0,0, 15, 8, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 3,1,4,2,11, 0,0,0, 15,15, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 3,1,4,2,11, 1,4,2, 15,15, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 3,3,4,2, 5, 1,4,2, 15,15, 1,0,1,0, 4,1));
      tv.push_back(mkv(8, 0,1,0,0, 5, 0,0,0, 15,15, 1,1,0,0, 4,1));
      tv.push_back(mkv(8, 4,6,4,5, 1, 0,0,0, 15,15, 0,0,0,0, 2,0));
      tv.push_back(mkv(8, 1,1,2,0, 5, 0,0,0, 15, 9, 1,1,0,0, 4,1));
      tv.push_back(mkv(8, 2,1,2,3,11, 0,0,0, 15,15, 1,0,0,1, 6,2));
      tv.push_back(mkv(8, 2,2,2,4,11, 0,0,0, 15,15, 0,0,0,0, 2,0));
      tv.push_back(mkv(8, 4,5,4,6, 5, 0,0,0, 15,15, 0,0,0,0, 2,0));
      tv.push_back(mkv(8, 5,4,6,5,11, 1,6,5, 15,15, 1,0,1,0, 4,1));
      tv.push_back(mkv(8, 3,4,4,3, 5, 1,4,3, 15,15, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 3,6,3,7,11, 0,0,0, 15,15, 1,1,0,0, 4,1));
      tv.push_back(mkv(8, 4,5,4,4, 5, 0,0,0, 15, 9, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,6,5,5, 5, 0,0,0, 15, 0, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,3,3,4,11, 0,0,0, 15, 6, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,3,3,4,11, 0,0,0, 15, 5, 1,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,6,3,5, 5, 0,0,0, 15,14, 1,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,6,3,5, 5, 0,0,0, 15, 6, 1,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,6,3,5, 5, 0,0,0, 15, 5, 0,0,0,0, 4,1));
      tv.push_back(mkv(8, 4,5,4,3, 5, 0,0,0, 15,15, 0,0,0,0, 2,0));
      tv.push_back(mkv(8, 4,6,4,3, 5, 0,0,0, 15,15, 0,0,0,0, 2,0));
      tv.push_back(mkv(10,3,8,3,6, 5, 0,0,0, 15,15, 1,0,0,1, 6,2));
      tv.push_back(mkv(10,3,8,3,6, 5, 0,0,0,  7,15, 0,0,0,0, 4,1));
      tv.push_back(mkv(10,12,8,12,7,5, 0,0,0, 15,15, 0,0,0,0, 2,0));
      tv.push_back(mkv(10,5,6,6,7,11, 1,6,7, 15,15, 1,0,1,0, 4,1));
      tv.push_back(mkv(10,2,8,2,9,11, 0,0,0, 15,15, 1,1,0,0, 4,1));
      tv.push_back(mkv(10,1,6,1,4, 5, 0,0,0, 15,15, 0,0,0,0, 2,0));

      q = '{default: 0};
      drive(8, q, 1'b0);
      drive(10, q, 1'b0);
      fill(15);
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset8", 8);
      chk_zero("reset10", 10);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (tv[i]) begin
         fill(15);
         q = tv[i].q;
         my = q.oy + ((q.pc == 5) ? -1 : 1);
         if (q.ox < tv[i].dim && my >= 0 && my < tv[i].dim)
            bd[q.ox][my] = tv[i].mid;
         if (q.nx < tv[i].dim && q.ny < tv[i].dim)
            bd[q.nx][q.ny] = tv[i].dst;
         e = model(tv[i].dim, q);
         e.valid = tv[i].valid; e.prom = tv[i].prom;
         e.epc = tv[i].epc; e.dbl = tv[i].dbl;
         e.lat = tv[i].lat; e.nrd = tv[i].nrd;
         run(tv[i].dim, q, e, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 240; i++) begin
         dim = (i % 3 == 2) ? 10 : 8;
         m = (dim == 8) ? 7 : 15;
         for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++)
               bd[x][y] = ($urandom_range(0, 1) != 0) ? 15 :
                          int'($urandom_range(0, 14));
         case ($urandom_range(0, 5))
            0, 1, 2: q.pc = 5;
            3, 4:    q.pc = 11;
            default: q.pc = int'($urandom_range(0, 15));
         endcase
         q.ox = $urandom_range(0, (dim == 8) ? 7 : 10);
         q.oy = $urandom_range(0, dim - 1);
         q.nx = (q.ox + int'($urandom_range(0, 2)) - 1) & m;
         q.ny = (q.oy + int'($urandom_range(0, 4)) - 2) & m;
         q.epv = $urandom_range(0, 1);
         if ($urandom_range(0, 2) != 0) begin
            q.epx = q.nx; q.epy = q.ny;
         end else begin
            q.epx = $urandom_range(0, m);
            q.epy = $urandom_range(0, m);
         end
         e = model(dim, q);
         run(dim, q, e, $sformatf("rnd%0d", i));
      end

      fill(15);
      q = '{ox: 4, oy: 6, nx: 4, ny: 5, pc: 5, default: 0};
      q2 = '{ox: 4, oy: 6, nx: 4, ny: 4, pc: 5, default: 0};
      @(negedge clk);
      drive(8, q, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(8, q2, 1'b1);
      ndone = 0;
      flat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         o = sample(8);
         if (o.done != 0) begin
            ndone++;
            if (flat == 0) flat = k;
         end
         if (k == 5) begin
            @(negedge clk);
            drive(8, q2, 1'b0);
         end
      end
      chk("busy start done count", ndone, 1);
      chk("busy start latency", flat, 4);
      chk("busy start valid", o.valid, 1);
      chk("busy start double_step", o.dbl, 0);
      chk("busy start idle", o.busy, 0);

      @(negedge clk);
      drive(8, q, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(8, q, 1'b0);
      @(posedge clk); #1;
      o = sample(8);
      chk("mid reset rd_en before", o.rd_en, 1);
      chk("mid reset rd_y before", o.ry, 5);
      reset_n = 1'b0;
      #1;
      chk_zero("mid reset", 8);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (b8.done) ndone++;
      end
      chk("mid reset no done", ndone, 0);
      chk("mid reset busy", int'(b8.busy), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
